// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types, constants and helpers for the runtime-
//                configurable serial sequence detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

   // Widest pattern the configuration record can carry.
   localparam int CFG_PAT_W = 32;
   // Width of the length field in the configuration record.
   localparam int CFG_LEN_W = 6;

   // Number of bits needed to hold a length value in the range 0..max_len.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Detector configuration: pattern, active length and overlap mode.
   typedef struct packed {
      logic [CFG_PAT_W-1:0] pattern;
      logic [CFG_LEN_W-1:0] len;
      logic                 overlap;
   } cfg_t;

   // Forces a length into the legal range 1..max_len.
   function automatic int clamp_len(input int len, input int max_len);
      if (len < 1) begin
         return 1;
      end
      if (len > max_len) begin
         return max_len;
      end
      return len;
   endfunction

   // Builds the reset-time configuration from the top-level parameters.
   function automatic cfg_t make_def_cfg(input logic [CFG_PAT_W-1:0] pattern,
                                         input int                   len,
                                         input int                   max_len,
                                         input logic                 overlap);
      cfg_t c;
      c.pattern = pattern;
      c.len     = CFG_LEN_W'(clamp_len(len, max_len));
      c.overlap = overlap;
      return c;
   endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_sat_cnt
//  Description : Up-counter with synchronous clear that sticks at its
//                all-ones value instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_sat_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise step unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : seq_det_sat_cnt
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial bit-sequence detector with run-time loadable pattern,
//                length and overlap mode. Provides a combinational (Mealy)
//                match, a registered copy one cycle later, and a saturating
//                match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 DEF_LEN     = 4,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
   parameter bit                 DEF_OVERLAP = 1'b1,
   parameter int                 CNT_W       = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        x,
   input  logic                        x_valid,
   input  logic                        cfg_load,
   input  logic [MAX_LEN-1:0]          cfg_pattern,
   input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
   input  logic                        cfg_overlap,
   output logic                        z,
   output logic                        z_q,
   output logic [CNT_W-1:0]            match_cnt
);

   localparam int LEN_W  = len_w(MAX_LEN);
   localparam int HIST_W = MAX_LEN - 1;

   // Reset-time configuration, length already clamped to 1..MAX_LEN.
   localparam cfg_t               DEF_CFG = make_def_cfg(CFG_PAT_W'(DEF_PATTERN), DEF_LEN,
                                                         MAX_LEN, DEF_OVERLAP);
   localparam logic [MAX_LEN-1:0] DEF_PAT = DEF_CFG.pattern[MAX_LEN-1:0];
   localparam logic [LEN_W-1:0]   DEF_LN  = LEN_W'(DEF_CFG.len);
   localparam logic               DEF_OVL = DEF_CFG.overlap;

   // Configuration registers.
   logic [MAX_LEN-1:0] pat_q,  pat_d;
   logic [LEN_W-1:0]   len_q,  len_d;
   logic               ovl_q,  ovl_d;

   // Detection state: previously received bits (newest in bit 0) and
   // the number of them that belong to the current hunt.
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;

   logic               z_d;

   logic [HIST_W-1:0]  hist_shift;
   logic [MAX_LEN-1:0] window;
   logic [LEN_W-1:0]   len_clamped;
   logic               mismatch;
   logic               enough;
   logic               match;

   // History shift; a 2-bit maximum pattern only needs the current bit kept.
   generate
      if (HIST_W == 1) begin : g_hist_short
         assign hist_shift = x;
      end else begin : g_hist_long
         assign hist_shift = {hist_q[HIST_W-2:0], x};
      end
   endgenerate

   // Compare the newest len bits (history plus the live bit) with the pattern.
   always_comb begin
      window   = {hist_q, x};
      mismatch = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len_q)) begin
            mismatch = mismatch | (window[i] ^ pat_q[i]);
         end
      end
      // fill >= len-1, written without the subtraction so len=1 cannot underflow.
      enough = (({1'b0, fill_q}) + (LEN_W+1)'(1)) >= {1'b0, len_q};
      match  = x_valid & ~cfg_load & ~rst & enough & ~mismatch;
   end

   assign z = match;

   // Bring an incoming length into 1..MAX_LEN before it is latched.
   always_comb begin
      len_clamped = cfg_len;
      if (cfg_len == '0) begin
         len_clamped = LEN_W'(1);
      end else if (int'(cfg_len) > MAX_LEN) begin
         len_clamped = LEN_W'(MAX_LEN);
      end
   end

   // Next-state: a load restarts the hunt; a valid bit advances it.
   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      z_d    = match;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         len_d  = len_clamped;
         ovl_d  = cfg_overlap;
         hist_d = '0;
         fill_d = '0;
      end else if (x_valid) begin
         hist_d = hist_shift;
         if (match && !ovl_q) begin
            // Non-overlapping: the next match must be built from fresh bits.
            fill_d = '0;
         end else if (fill_q != LEN_W'(MAX_LEN)) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end
   end

   // State registers with synchronous reset to the default configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= DEF_PAT;
         len_q  <= DEF_LN;
         ovl_q  <= DEF_OVL;
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
      end
   end

   // Match counter, cleared whenever a new configuration is loaded.
   seq_det_sat_cnt #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cfg_load),
      .inc (match),
      .cnt (match_cnt)
   );

endmodule : seq_detector_param
`default_nettype wire
